// File: rtl/frame_pixel_scanner.sv
// Raster sweep sequencer: issues (x, y, ld) to a per-pixel renderer and forwards the
// renderer's registered colour to the VGA adapter as a two-stage pipelined plot write.
module frame_pixel_scanner #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frameStart,
  input  logic [2:0] colorIn,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       ld,
  output logic [7:0] vgaX,
  output logic [7:0] vgaY,
  output logic [2:0] vgaColor,
  output logic       plot,
  output logic       busy,
  output logic       frameDone
);

  // Compare against the last index so WIDTH/HEIGHT of 256 never needs a 9th bit.
  localparam logic [7:0] XMax = 8'(WIDTH - 1);
  localparam logic [7:0] YMax = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e     state;
  logic       pending;
  logic       drainCnt;
  logic [7:0] s1X;
  logic [7:0] s1Y;
  logic       s1Valid;

  logic lastPix;
  logic startReq;

  assign lastPix  = (x == XMax) && (y == YMax);
  assign startReq = frameStart | pending;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= StIdle;
      pending   <= 1'b0;
      drainCnt  <= 1'b0;
      s1X       <= 8'd0;
      s1Y       <= 8'd0;
      s1Valid   <= 1'b0;
      x         <= 8'd0;
      y         <= 8'd0;
      ld        <= 1'b0;
      vgaX      <= 8'd0;
      vgaY      <= 8'd0;
      vgaColor  <= 3'd0;
      plot      <= 1'b0;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      // Stage 1 tracks the coordinate issued last cycle; the renderer's colour for it
      // arrives one cycle later and joins it in stage 2.
      s1X       <= x;
      s1Y       <= y;
      s1Valid   <= ld;
      vgaX      <= s1X;
      vgaY      <= s1Y;
      vgaColor  <= colorIn;
      plot      <= s1Valid;
      frameDone <= 1'b0;

      case (state)
        StIdle: begin
          if (startReq) begin
            state   <= StScan;
            x       <= 8'd0;
            y       <= 8'd0;
            ld      <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
          end
        end
        StScan: begin
          if (frameStart) pending <= 1'b1;
          if (lastPix) begin
            state    <= StDrain;
            ld       <= 1'b0;
            drainCnt <= 1'b0;
          end else if (x == XMax) begin
            x <= 8'd0;
            y <= y + 8'd1;
          end else begin
            x <= x + 8'd1;
          end
        end
        StDrain: begin
          if (!drainCnt) begin
            drainCnt  <= 1'b1;
            frameDone <= 1'b1;
            if (frameStart) pending <= 1'b1;
          end else if (startReq) begin
            // A request seen on the final drain edge restarts with no idle gap.
            state   <= StScan;
            x       <= 8'd0;
            y       <= 8'd0;
            ld      <= 1'b1;
            pending <= 1'b0;
          end else begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/frame_pixel_scanner.md
# frame_pixel_scanner

Upstream sequencer for the per-pixel renderers. On each frame-start request it sweeps every screen coordinate in raster order, issuing (x, y) plus a one-cycle load strobe to the renderer. It captures the renderer's registered colour and emits a pipelined plot write (coordinates, colour, plot strobe) to the VGA adapter at one pixel per clock. It also queues at most one frame request that arrives mid-sweep.

## Interface
Parameters:
- WIDTH, 160, pixels per line; legal 1..256.
- HEIGHT, 120, lines per frame; legal 1..256.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- frameStart  in  1  request to draw one frame; sampled every cycle.
- colorIn  in  3  renderer colour; valid the cycle after ld was high.
- x  out  8  scan column to renderer.
- y  out  8  scan row to renderer.
- ld  out  1  renderer load strobe; renderer latches colour at the end of each ld-high cycle.
- vgaX  out  8  plot column.
- vgaY  out  8  plot row.
- vgaColor  out  3  plot colour.
- plot  out  1  write-enable to the VGA adapter.
- busy  out  1  high from the first ld cycle through the last plot cycle.
- frameDone  out  1  one-cycle pulse coinciding with the last plot of a frame.

## Operation
- All outputs are registered. On resetn low, every output is 0, state is IDLE and the pending flag is cleared.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE:
  - On frameStart=1 or pending=1, go to SCAN with x=0, y=0, ld=1.
  - Clear pending on that transition.
- SCAN, stage 0: ld=1 every cycle.
  - x increments each cycle.
  - At x=WIDTH-1, x wraps to 0 and y increments.
  - After (WIDTH-1, HEIGHT-1) is issued, go to DRAIN with ld=0; x and y hold their last values.
- Stage 1: capture register holds the stage-0 coordinates and a valid bit.
  - colorIn is sampled at the end of the cycle after ld.
- Stage 2 outputs: vgaX, vgaY and vgaColor come from stage 1, with plot = stage-1 valid.
  - Each plot occurs exactly 2 cycles after the ld for the same coordinate.
- DRAIN: lasts 2 cycles while the pipeline empties.
  - frameDone=1 in the cycle of the final plot.
  - Then go to IDLE, or go directly to SCAN if pending=1; in that case the next frame's first ld is in the cycle after frameDone.
- Pending flag:
  - Set by frameStart=1 in SCAN or DRAIN. Multiple requests collapse into one.
  - A frameStart coincident with the final DRAIN cycle also sets pending, so it is serviced immediately.
- Counter widths: x and y are 8-bit. Compare against WIDTH-1 and HEIGHT-1, never against 256, so WIDTH=256 must not overflow.
- Reset mid-frame aborts immediately: plot, ld and busy drop asynchronously, and no frameDone is generated.

## Timing
- N = WIDTH*HEIGHT. With frameStart sampled at edge E0:
  - ld is high in cycles 1..N.
  - plot is high in cycles 3..N+2; it never de-asserts mid-frame.
  - frameDone is high in cycle N+2 only.
- busy is high in cycles 1..N+2.
- Start to first plot: 3 cycles. Frame period with back-to-back requests: N+2 cycles.
- frameStart held high continuously causes back-to-back frames. Its level is not edge-detected.
- WIDTH=1 or HEIGHT=1: same rules apply. The raster degenerates to a single column or row; with both equal to 1, N=1.

## Test plan
- WIDTH=4, HEIGHT=3, single frameStart pulse:
  - Check ld for cycles 1..12 and the sequence (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2).
  - Check plot in cycles 3..14 with matching vgaX/vgaY, and frameDone only in cycle 14.
- Renderer model returning colorIn = (x+y)&7 registered on ld: check every plotted vgaColor equals (vgaX+vgaY)&7.
- frameStart pulsed in cycles 5 and 9 of a 4x3 frame:
  - Exactly one extra frame runs.
  - Its first ld is in cycle 15, the cycle after frameDone; no gap or duplicate plot.
- frameStart held high for 40 cycles (4x3): frames start every 14 cycles, and frameDone pulses at cycles 14, 28, 42.
- resetn dropped at cycle 7 of a frame: outputs are 0 immediately, no frameDone follows, and the next frameStart restarts at (0,0).
- WIDTH=256, HEIGHT=2:
  - x wraps from 255 to 0 with y going 0 to 1.
  - The last plot is (255,1) in cycle 514.
